// File: rtl/wb_master_mux.sv
// rtl/wb_master_mux.sv - Wishbone master-side mux routing the granted master to the slave bus, with stall watchdog
module wb_master_mux #(
    parameter int N       = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    localparam int SW     = DW / 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    gnt_i,
    input  logic [N-1:0]    m_cyc_i,
    input  logic [N-1:0]    m_stb_i,
    input  logic [N-1:0]    m_we_i,
    input  logic [N*AW-1:0] m_adr_i,
    input  logic [N*DW-1:0] m_dat_i,
    input  logic [N*SW-1:0] m_sel_i,
    output logic [DW-1:0]   m_dat_o,
    output logic [N-1:0]    m_ack_o,
    output logic [N-1:0]    m_err_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [SW-1:0]   s_sel_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    output logic            timeout_o,
    output logic [7:0]      timeout_cnt_o
);

    localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ABORT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    tcnt_q, tcnt_d;

    logic [N-1:0]  gnt_low;
    logic          cyc_g, stb_g, we_g;
    logic [AW-1:0] adr_g;
    logic [DW-1:0] dat_g;
    logic [SW-1:0] sel_g;
    logic          busy, abort, stall, ack_g, err_g;

    assign gnt_low = gnt_i & (~gnt_i + 1'b1);

    // Descending scan so the lowest granted index is the one left selected.
    always_comb begin
        cyc_g = 1'b0;
        stb_g = 1'b0;
        we_g  = 1'b0;
        adr_g = '0;
        dat_g = '0;
        sel_g = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (gnt_i[k]) begin
                cyc_g = m_cyc_i[k];
                stb_g = m_stb_i[k];
                we_g  = m_we_i[k];
                adr_g = m_adr_i[k*AW +: AW];
                dat_g = m_dat_i[k*DW +: DW];
                sel_g = m_sel_i[k*SW +: SW];
            end
        end
    end

    assign busy  = (state_q == ST_BUSY);
    assign abort = (state_q == ST_ABORT);

    assign s_cyc_o = cyc_g & ~abort & ~rst_i;
    assign s_stb_o = stb_g & ~abort & ~rst_i;
    assign s_we_o  = we_g;
    assign s_adr_o = adr_g;
    assign s_dat_o = dat_g;
    assign s_sel_o = sel_g;

    assign ack_g   = busy & s_ack_i & stb_g;
    assign err_g   = ((busy & s_err_i) | abort) & stb_g;
    assign m_ack_o = {N{ack_g}} & gnt_low;
    assign m_err_o = {N{err_g}} & gnt_low;
    assign m_dat_o = s_dat_i;

    assign timeout_o     = timeout_q;
    assign timeout_cnt_o = tcnt_q;

    assign stall = s_cyc_o & s_stb_o & ~s_ack_i & ~s_err_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        tcnt_d    = tcnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (cyc_g) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (!cyc_g) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (stall && TIMEOUT != 0) begin
                    if (cnt_q == LAST) begin
                        state_d   = ST_ABORT;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                        if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ST_ABORT: begin
                cnt_d = '0;
                if (!cyc_g) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            tcnt_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            tcnt_q    <= tcnt_d;
        end
    end

endmodule

// File: tb/tb_wb_master_mux.sv
// tb/tb_wb_master_mux.sv - randomized and directed bench for wb_master_mux against a phase/stall-run model
module tb_wb_master_mux;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int ND = 2;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] gnt, mcyc, mstb, mwe;
    logic [N-1:0][AW-1:0] madr;
    logic [N-1:0][DW-1:0] mdat;
    logic [N-1:0][SW-1:0] msel;
    logic [DW-1:0] sdat;
    logic sack, serr;

    logic [ND-1:0][DW-1:0] o_mdat;
    logic [ND-1:0][N-1:0]  o_mack, o_merr;
    logic [ND-1:0]         o_scyc, o_sstb, o_swe, o_tmo;
    logic [ND-1:0][AW-1:0] o_sadr;
    logic [ND-1:0][DW-1:0] o_sdat;
    logic [ND-1:0][SW-1:0] o_ssel;
    logic [ND-1:0][7:0]    o_tcnt;

    int n_cmp = 0;
    int n_bad = 0;

    int tmo_val [ND] = '{4, 0};
    int ph  [ND];
    int run [ND];
    int tc  [ND];
    bit pl  [ND];

    always #5 clk = ~clk;

    for (genvar d = 0; d < ND; d++) begin : g_dut
        wb_master_mux #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(d == 0 ? 4 : 0)) u_dut (
            .clk_i(clk), .rst_i(rst), .gnt_i(gnt),
            .m_cyc_i(mcyc), .m_stb_i(mstb), .m_we_i(mwe),
            .m_adr_i(madr), .m_dat_i(mdat), .m_sel_i(msel),
            .m_dat_o(o_mdat[d]), .m_ack_o(o_mack[d]), .m_err_o(o_merr[d]),
            .s_cyc_o(o_scyc[d]), .s_stb_o(o_sstb[d]), .s_we_o(o_swe[d]),
            .s_adr_o(o_sadr[d]), .s_dat_o(o_sdat[d]), .s_sel_o(o_ssel[d]),
            .s_dat_i(sdat), .s_ack_i(sack), .s_err_i(serr),
            .timeout_o(o_tmo[d]), .timeout_cnt_o(o_tcnt[d])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        int gl;
        logic cyc, stb, we, e_scyc, e_sstb;
        logic [N-1:0] e_ack, e_err;
        int nph [ND];
        int nrun [ND];
        int ntc [ND];
        bit npl [ND];
        string p;
        @(negedge clk);
        gl = -1;
        for (int k = N - 1; k >= 0; k--) if (gnt[k]) gl = k;
        cyc = (gl >= 0) ? mcyc[gl] : 1'b0;
        stb = (gl >= 0) ? mstb[gl] : 1'b0;
        we  = (gl >= 0) ? mwe[gl]  : 1'b0;
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                ph[d] = 0; run[d] = 0; pl[d] = 0; tc[d] = 0;
            end
            p = (d == 0) ? "t4." : "t0.";
            e_scyc = cyc && ph[d] != 2 && !rst;
            e_sstb = stb && ph[d] != 2 && !rst;
            e_ack = '0;
            e_err = '0;
            if (gl >= 0 && stb && !rst) begin
                if (ph[d] == 1 && sack) e_ack[gl] = 1'b1;
                if ((ph[d] == 1 && serr) || ph[d] == 2) e_err[gl] = 1'b1;
            end
            chk({p, "s_cyc"}, 64'(o_scyc[d]), 64'(e_scyc));
            chk({p, "s_stb"}, 64'(o_sstb[d]), 64'(e_sstb));
            chk({p, "m_ack"}, 64'(o_mack[d]), 64'(e_ack));
            chk({p, "m_err"}, 64'(o_merr[d]), 64'(e_err));
            chk({p, "timeout"}, 64'(o_tmo[d]), 64'(pl[d]));
            chk({p, "timeout_cnt"}, 64'(o_tcnt[d]), 64'(tc[d]));
            chk({p, "m_dat"}, 64'(o_mdat[d]), 64'(sdat));
            if (!rst) begin
                chk({p, "s_we"}, 64'(o_swe[d]), 64'(we));
                chk({p, "s_adr"}, 64'(o_sadr[d]), (gl >= 0) ? 64'(madr[gl]) : 64'd0);
                chk({p, "s_dat"}, 64'(o_sdat[d]), (gl >= 0) ? 64'(mdat[gl]) : 64'd0);
                chk({p, "s_sel"}, 64'(o_ssel[d]), (gl >= 0) ? 64'(msel[gl]) : 64'd0);
            end
            nph[d] = ph[d]; nrun[d] = run[d]; ntc[d] = tc[d]; npl[d] = 0;
            if (!rst) begin
                if (ph[d] == 0) begin
                    nrun[d] = 0;
                    if (cyc) nph[d] = 1;
                end else if (ph[d] == 1) begin
                    if (!cyc) begin
                        nph[d] = 0; nrun[d] = 0;
                    end else if (e_scyc && e_sstb && !sack && !serr) begin
                        if (tmo_val[d] != 0 && run[d] + 1 == tmo_val[d]) begin
                            nph[d] = 2; nrun[d] = 0; npl[d] = 1;
                            ntc[d] = (tc[d] < 255) ? tc[d] + 1 : 255;
                        end else begin
                            nrun[d] = run[d] + 1;
                        end
                    end else begin
                        nrun[d] = 0;
                    end
                end else if (!cyc) begin
                    nph[d] = 0;
                end
            end
        end
        @(posedge clk);
        for (int d = 0; d < ND; d++) begin
            ph[d] = nph[d]; run[d] = nrun[d]; tc[d] = ntc[d]; pl[d] = npl[d];
        end
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rnd_inputs();
        int gl;
        int r;
        for (int k = 0; k < N; k++) begin
            if (mcyc[k]) begin
                if ($urandom_range(0, 7) == 0) begin
                    mcyc[k] = 1'b0; mstb[k] = 1'b0;
                end else begin
                    mstb[k] = ($urandom_range(0, 9) < 6);
                end
            end else if ($urandom_range(0, 3) == 0) begin
                mcyc[k] = 1'b1;
            end
            mwe[k]  = $urandom_range(0, 1);
            madr[k] = $urandom;
            mdat[k] = $urandom;
            msel[k] = SW'($urandom);
        end
        gl = -1;
        for (int k = N - 1; k >= 0; k--) if (gnt[k]) gl = k;
        if ((gl < 0 || !mcyc[gl]) && $urandom_range(0, 2) == 0) gnt = N'($urandom_range(0, 3));
        r = $urandom_range(0, 99);
        sack = (r < 25);
        serr = (r >= 25 && r < 30);
        sdat = $urandom;
        rst  = ($urandom_range(0, 499) == 0);
    endtask

    initial begin
        rst = 1'b0; gnt = '0; mcyc = '0; mstb = '0; mwe = '0;
        madr = '0; mdat = '0; msel = '0; sdat = '0; sack = 1'b0; serr = 1'b0;
        for (int d = 0; d < ND; d++) begin
            ph[d] = 0; run[d] = 0; tc[d] = 0; pl[d] = 0;
        end
        #1 rst = 1'b1;
        steps(2);
        rst = 1'b0;

        // master 0 write, acked one cycle after the strobe
        gnt = 2'b01; mcyc[0] = 1'b1; step();
        mstb[0] = 1'b1; mwe[0] = 1'b1; madr[0] = 32'h10; mdat[0] = 32'hDEADBEEF; msel[0] = 4'hF; step();
        sack = 1'b1; step();
        sack = 1'b0; mstb[0] = 1'b0; mcyc[0] = 1'b0; step();

        // master 1 read while master 0 also strobes
        gnt = 2'b10; mcyc = 2'b11; mstb[0] = 1'b1; mwe = 2'b01; step();
        mstb[1] = 1'b1; madr[1] = 32'h44; sdat = 32'h12345678; step();
        sack = 1'b1; step();
        sack = 1'b0; mcyc = '0; mstb = '0; step();

        // stall into abort, then two more strobes while aborted
        gnt = 2'b01; mcyc[0] = 1'b1; step();
        mstb[0] = 1'b1; steps(6);
        mstb[0] = 1'b0; step();
        mstb[0] = 1'b1; step();
        mstb[0] = 1'b0; step();
        mstb[0] = 1'b1; step();
        mstb[0] = 1'b0; mcyc[0] = 1'b0; steps(2);

        // ack on the last allowed cycle, then a fresh budget for the next strobe
        mcyc[0] = 1'b1; step();
        mstb[0] = 1'b1; steps(3);
        sack = 1'b1; step();
        sack = 1'b0; steps(3);
        sack = 1'b1; step();
        sack = 1'b0; mstb[0] = 1'b0; mcyc[0] = 1'b0; step();

        // reset in the middle of a stalled strobe, cyc held through release
        mcyc[0] = 1'b1; step();
        mstb[0] = 1'b1; steps(2);
        rst = 1'b1; step();
        rst = 1'b0; steps(3);
        mstb[0] = 1'b0; mcyc[0] = 1'b0; step();

        // long stall: watchdog-disabled instance never aborts
        mcyc[0] = 1'b1; step();
        mstb[0] = 1'b1; steps(1000);
        mstb[0] = 1'b0; mcyc[0] = 1'b0; step();

        for (int i = 0; i < 3000; i++) begin
            rnd_inputs();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
